// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward controller for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16,
    parameter bit REG0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_vld,
    input  logic              id_rt_vld,
    input  logic              id_is_hlt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    output logic              pc_wen,
    output logic              ifid_wen,
    output logic              ifid_nop,
    output logic              idex_wen,
    output logic              idex_nop,
    output logic              exmem_wen,
    output logic              memwb_wen,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              hlt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic ex_rs_m, ex_rt_m, mem_rs_m, mem_rt_m;
    logic load_use;

    // WB results reach ID through the regfile's write-before-read, so WB is never a source here.
    logic unused_wb;
    assign unused_wb = ^{wb_rd, wb_regwrite};

    function automatic logic match(input logic regwrite, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] r);
        return regwrite && (rd == r) && ((r != '0) || !REG0_ZERO);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m);
        if (ex_m) begin
            return FWD_MEM;
        end else if (mem_m) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        ex_rs_m  = id_rs_vld && match(ex_regwrite, ex_rd, id_rs);
        ex_rt_m  = id_rt_vld && match(ex_regwrite, ex_rd, id_rt);
        mem_rs_m = id_rs_vld && match(mem_regwrite, mem_rd, id_rs);
        mem_rt_m = id_rt_vld && match(mem_regwrite, mem_rd, id_rt);
        load_use = ex_memread && (ex_rs_m || ex_rt_m);
    end

    always_comb begin
        pc_wen    = 1'b0;
        ifid_wen  = 1'b0;
        ifid_nop  = 1'b0;
        idex_wen  = 1'b0;
        idex_nop  = 1'b0;
        exmem_wen = 1'b0;
        memwb_wen = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_RUN: begin
                exmem_wen = !dmem_busy;
                memwb_wen = !dmem_busy;
                if (dmem_busy) begin
                    pc_wen = 1'b0;
                end else if (ex_br_taken) begin
                    pc_wen   = 1'b1;
                    ifid_wen = 1'b1;
                    ifid_nop = 1'b1;
                    idex_wen = 1'b1;
                    idex_nop = 1'b1;
                end else if (load_use) begin
                    idex_wen = 1'b1;
                    idex_nop = 1'b1;
                end else if (imem_busy) begin
                    ifid_wen = 1'b1;
                    ifid_nop = 1'b1;
                    idex_wen = 1'b1;
                end else begin
                    pc_wen   = 1'b1;
                    ifid_wen = 1'b1;
                    idex_wen = 1'b1;
                end
                if (id_is_hlt && !ex_br_taken && !load_use && !dmem_busy) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DC_W'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                // Older instructions keep flowing out while nothing new enters.
                if (!dmem_busy) begin
                    ifid_wen  = 1'b1;
                    ifid_nop  = 1'b1;
                    idex_wen  = 1'b1;
                    idex_nop  = 1'b1;
                    exmem_wen = 1'b1;
                    memwb_wen = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - DC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (idex_wen) begin
            fwd_a_d = idex_nop ? FWD_RF : fwd_sel(ex_rs_m, mem_rs_m);
            fwd_b_d = idex_nop ? FWD_RF : fwd_sel(ex_rt_m, mem_rt_m);
        end
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && !pc_wen && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign hlt       = (state_q == ST_HALTED);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    localparam int REG_AW    = 4;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic              rst_n;
        logic [REG_AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
        logic              id_rs_vld, id_rt_vld, id_is_hlt;
        logic              ex_regwrite, mem_regwrite, wb_regwrite;
        logic              ex_memread, ex_br_taken, imem_busy, dmem_busy;
    } stim_t;

    typedef struct {
        logic [6:0]       ctl;
        logic [1:0]       fa, fb;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic              id_rs_vld, id_rt_vld, id_is_hlt;
    logic              ex_regwrite, mem_regwrite, wb_regwrite;
    logic              ex_memread, ex_br_taken, imem_busy, dmem_busy;
    logic              pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem_wen, memwb_wen;
    logic [1:0]        fwd_a, fwd_b;
    logic              hlt;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model state: mode 0 = running, 1 = draining, 2 = halted.
    int m_mode = 0;
    int m_left = 0;
    int m_fa = 0;
    int m_fb = 0;
    int m_cnt = 0;
    int halted_cycles = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W), .REG0_ZERO(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .id_is_hlt(id_is_hlt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_nop(ifid_nop),
        .idex_wen(idex_wen), .idex_nop(idex_nop),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .hlt(hlt), .stall_cnt(stall_cnt)
    );

    function automatic bit writes(logic we, logic [REG_AW-1:0] rd, logic [REG_AW-1:0] r, logic vld);
        return vld && we && rd == r && r != 0;
    endfunction

    function automatic int pick_src(logic [REG_AW-1:0] r, logic vld, stim_t s);
        if (writes(s.ex_regwrite, s.ex_rd, r, vld)) return 2;
        if (writes(s.mem_regwrite, s.mem_rd, r, vld)) return 1;
        return 0;
    endfunction

    function automatic bit is_load_use(stim_t s);
        return s.ex_memread && (writes(s.ex_regwrite, s.ex_rd, s.id_rs, s.id_rs_vld) ||
                                writes(s.ex_regwrite, s.ex_rd, s.id_rt, s.id_rt_vld));
    endfunction

    // Control word order: pc, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem, memwb.
    function automatic logic [6:0] model_ctl(stim_t s);
        if (m_mode == 2) return 7'b000_0000;
        if (s.dmem_busy) return 7'b000_0000;
        if (m_mode == 1) return 7'b011_1111;
        if (s.ex_br_taken) return 7'b111_1111;
        if (is_load_use(s)) return 7'b000_1111;
        if (s.imem_busy) return 7'b011_1011;
        return 7'b110_1011;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1;
        s.id_rs = '0; s.id_rt = '0; s.ex_rd = '0; s.mem_rd = '0; s.wb_rd = '0;
        s.id_rs_vld = 1'b0; s.id_rt_vld = 1'b0; s.id_is_hlt = 1'b0;
        s.ex_regwrite = 1'b0; s.mem_regwrite = 1'b0; s.wb_regwrite = 1'b0;
        s.ex_memread = 1'b0; s.ex_br_taken = 1'b0; s.imem_busy = 1'b0; s.dmem_busy = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n = !(($urandom_range(0, 199) == 0) || (halted_cycles > 4));
        s.id_rs = REG_AW'($urandom_range(0, 3));
        s.id_rt = REG_AW'($urandom_range(0, 3));
        s.ex_rd = REG_AW'($urandom_range(0, 3));
        s.mem_rd = REG_AW'($urandom_range(0, 3));
        s.wb_rd = REG_AW'($urandom_range(0, 3));
        s.id_rs_vld = $urandom_range(0, 9) < 8;
        s.id_rt_vld = $urandom_range(0, 9) < 6;
        s.id_is_hlt = $urandom_range(0, 39) == 0;
        s.ex_regwrite = $urandom_range(0, 9) < 7;
        s.mem_regwrite = $urandom_range(0, 9) < 7;
        s.wb_regwrite = $urandom_range(0, 9) < 7;
        s.ex_memread = $urandom_range(0, 9) < 3;
        s.ex_br_taken = $urandom_range(0, 9) == 0;
        s.imem_busy = $urandom_range(0, 19) < 3;
        s.dmem_busy = $urandom_range(0, 9) == 0;
        return s;
    endfunction

    // Called at posedge+1: drive, predict, then advance the model across the next edge.
    task automatic run_cycle(stim_t s);
        exp_t e;
        logic [6:0] c;
        rst_n = s.rst_n; id_rs = s.id_rs; id_rt = s.id_rt; ex_rd = s.ex_rd;
        mem_rd = s.mem_rd; wb_rd = s.wb_rd; id_rs_vld = s.id_rs_vld; id_rt_vld = s.id_rt_vld;
        id_is_hlt = s.id_is_hlt; ex_regwrite = s.ex_regwrite; mem_regwrite = s.mem_regwrite;
        wb_regwrite = s.wb_regwrite; ex_memread = s.ex_memread; ex_br_taken = s.ex_br_taken;
        imem_busy = s.imem_busy; dmem_busy = s.dmem_busy;
        c = model_ctl(s);
        e.ctl = c;
        e.fa = 2'(m_fa == 2 ? 2 : m_fa);
        e.fb = 2'(m_fb == 2 ? 2 : m_fb);
        e.hlt = (m_mode == 2);
        e.cnt = CNT_W'(m_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        if (!s.rst_n) begin
            m_mode = 0; m_left = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            if (m_mode == 0 && !c[6] && m_cnt < CNT_MAX) m_cnt++;
            if (c[3]) begin
                m_fa = c[2] ? 0 : pick_src(s.id_rs, s.id_rs_vld, s);
                m_fb = c[2] ? 0 : pick_src(s.id_rt, s.id_rt_vld, s);
            end
            if (m_mode == 0) begin
                if (s.id_is_hlt && !s.ex_br_taken && !is_load_use(s) && !s.dmem_busy) begin
                    m_mode = 1;
                    m_left = DRAIN_CYC - 1;
                end
            end else if (m_mode == 1 && !s.dmem_busy) begin
                if (m_left == 0) m_mode = 2;
                else m_left--;
            end
        end
        halted_cycles = (m_mode == 2) ? halted_cycles + 1 : 0;
        #1;
    endtask

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctl", int'({pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem_wen, memwb_wen}),
                    int'(e.ctl));
                chk("fwd", int'({fwd_a, fwd_b}), int'({e.fa, e.fb}));
                chk("hlt", int'(hlt), int'(e.hlt));
                chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        rst_n = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_rs_vld = 0; id_rt_vld = 0; id_is_hlt = 0; ex_regwrite = 0; mem_regwrite = 0;
        wb_regwrite = 0; ex_memread = 0; ex_br_taken = 0; imem_busy = 0; dmem_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        run_cycle(s);
        s = idle();
        run_cycle(s);

        // EX forward, then EX and MEM both write r3: EX wins.
        s = idle(); s.ex_rd = 3; s.ex_regwrite = 1; s.id_rs = 3; s.id_rs_vld = 1;
        run_cycle(s);
        s.mem_rd = 3; s.mem_regwrite = 1;
        run_cycle(s);
        run_cycle(idle());

        // Load-use, then the load sits in MEM.
        s = idle(); s.ex_rd = 5; s.ex_regwrite = 1; s.ex_memread = 1; s.id_rt = 5; s.id_rt_vld = 1;
        run_cycle(s);
        s.ex_memread = 0; s.ex_regwrite = 0; s.mem_rd = 5; s.mem_regwrite = 1;
        run_cycle(s);
        run_cycle(idle());

        // Load-use together with a taken branch.
        s = idle(); s.ex_rd = 2; s.ex_regwrite = 1; s.ex_memread = 1; s.id_rs = 2; s.id_rs_vld = 1;
        s.ex_br_taken = 1;
        run_cycle(s);

        // Load-use frozen by dmem_busy for 4 cycles.
        s.ex_br_taken = 0; s.dmem_busy = 1;
        repeat (4) run_cycle(s);
        s.dmem_busy = 0;
        run_cycle(s);
        run_cycle(idle());

        // Register 0 never hazards.
        s = idle(); s.ex_rd = 0; s.ex_regwrite = 1; s.ex_memread = 1; s.id_rs = 0; s.id_rs_vld = 1;
        run_cycle(s);
        run_cycle(idle());

        // HLT with dmem_busy inside the drain, then reset from HALTED.
        s = idle(); s.id_is_hlt = 1;
        run_cycle(s);
        run_cycle(idle());
        s = idle(); s.dmem_busy = 1;
        repeat (2) run_cycle(s);
        repeat (5) run_cycle(idle());
        s = idle(); s.rst_n = 0;
        run_cycle(s);
        repeat (2) run_cycle(idle());

        // Reset in the middle of a drain.
        s = idle(); s.id_is_hlt = 1;
        run_cycle(s);
        run_cycle(idle());
        s = idle(); s.rst_n = 0;
        run_cycle(s);
        run_cycle(idle());

        for (int i = 0; i < 3000; i++) begin
            run_cycle(rand_stim());
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
